// File: rtl/adc_block_averager_pkg.sv
// Shared definitions for the ADC block averager: FSM encoding, default
// parameter values, accumulator width derivation and min/max sentinels.
package adc_block_averager_pkg;

   // Default block parameters
   localparam int DEF_ADC_WIDTH     = 12;
   localparam int DEF_MAX_LOG2_N    = 10;
   localparam int DEF_SETTLE_CYCLES = 4;

   // Averager control states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACCUM  = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   // Accumulator wide enough for 2^max_log2_n full-scale samples
   function automatic int acc_width(input int adc_width, input int max_log2_n);
      return adc_width + max_log2_n;
   endfunction

   // Largest positive two's-complement value of a given width (low bits)
   function automatic logic [31:0] pos_sentinel(input int width);
      return (32'h1 << (width - 1)) - 32'h1;
   endfunction

   // Most negative two's-complement value of a given width (low bits)
   function automatic logic [31:0] neg_sentinel(input int width);
      return 32'h1 << (width - 1);
   endfunction

endpackage

// File: rtl/adc_block_averager_minmax.sv
// Running signed minimum/maximum of a sample stream. A clear loads the
// sentinels so the first enabled sample always replaces both extrema.
module adc_minmax_tracker
   import adc_block_averager_pkg::*;
#(
   parameter int WIDTH = DEF_ADC_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] min_val,
   output logic [WIDTH-1:0] max_val
);

   localparam logic [WIDTH-1:0] POS_SENT = WIDTH'(pos_sentinel(WIDTH));
   localparam logic [WIDTH-1:0] NEG_SENT = WIDTH'(neg_sentinel(WIDTH));

   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] max_q, max_d;

   // Next extrema: clear has priority over an update
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (clear) begin
         min_d = POS_SENT;
         max_d = NEG_SENT;
      end else if (en) begin
         if ($signed(sample) < $signed(min_q)) min_d = sample;
         if ($signed(sample) > $signed(max_q)) max_d = sample;
      end
   end

   // Extrema registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= POS_SENT;
         max_q <= NEG_SENT;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_val = min_q;
   assign max_val = max_q;

endmodule

// File: rtl/adc_block_averager.sv
// ADC block averager: registers the raw sample stream, and on START drops a
// settle window then sums 2^L samples, reporting sum, floor-mean, min and
// max with a one-cycle DONE pulse. Results hold until the next block ends.
module adc_block_averager
   import adc_block_averager_pkg::*;
#(
   parameter int ADC_WIDTH     = DEF_ADC_WIDTH,
   parameter int MAX_LOG2_N    = DEF_MAX_LOG2_N,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                              ADC_CLK,
   input  logic                              RST_N,
   input  logic [ADC_WIDTH-1:0]              ADC_DATA_IN,
   input  logic                              START,
   input  logic [3:0]                        LOG2_N,
   output logic                              BUSY,
   output logic                              DONE,
   output logic [ADC_WIDTH+MAX_LOG2_N-1:0]   SUM_OUT,
   output logic [ADC_WIDTH-1:0]              MEAN_OUT,
   output logic [ADC_WIDTH-1:0]              MIN_OUT,
   output logic [ADC_WIDTH-1:0]              MAX_OUT
);

   localparam int ACC_WIDTH  = acc_width(ADC_WIDTH, MAX_LOG2_N);
   localparam int SET_WIDTH  = $clog2(SETTLE_CYCLES + 1);
   // One counter serves both the settle window and the sample count
   localparam int CNT_WIDTH  = (MAX_LOG2_N + 1 > SET_WIDTH) ? MAX_LOG2_N + 1 : SET_WIDTH;
   localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
   localparam logic [3:0]           MAX_L       = 4'(MAX_LOG2_N);

   state_t                 state_q, state_d;
   logic [ADC_WIDTH-1:0]   s_q, s_d;
   logic [3:0]             l_q, l_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [ACC_WIDTH-1:0]   sum_q, sum_d;
   logic [ADC_WIDTH-1:0]   mean_q, mean_d;
   logic [ADC_WIDTH-1:0]   min_q, min_d;
   logic [ADC_WIDTH-1:0]   max_q, max_d;

   logic                   trk_clear;
   logic                   trk_en;
   logic [ADC_WIDTH-1:0]   trk_min;
   logic [ADC_WIDTH-1:0]   trk_max;
   logic [CNT_WIDTH-1:0]   block_last;
   logic [ACC_WIDTH-1:0]   s_ext;
   logic signed [ACC_WIDTH-1:0] acc_shift;
   logic [3:0]             l_clamped;

   adc_minmax_tracker #(
      .WIDTH (ADC_WIDTH)
   ) u_minmax (
      .clk     (ADC_CLK),
      .rst_n   (RST_N),
      .clear   (trk_clear),
      .en      (trk_en),
      .sample  (s_q),
      .min_val (trk_min),
      .max_val (trk_max)
   );

   // Derived datapath values: block length, sign extension, floor-mean
   always_comb begin
      l_clamped  = (LOG2_N > MAX_L) ? MAX_L : LOG2_N;
      block_last = (CNT_ONE << l_q) - CNT_ONE;
      s_ext      = {{MAX_LOG2_N{s_q[ADC_WIDTH-1]}}, s_q};
      acc_shift  = $signed(acc_q) >>> l_q;
   end

   // Next-state and datapath control; FIN lasts one cycle and publishes
   always_comb begin
      state_d   = state_q;
      s_d       = ADC_DATA_IN;
      l_d       = l_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sum_d     = sum_q;
      mean_d    = mean_q;
      min_d     = min_q;
      max_d     = max_q;
      trk_clear = 1'b0;
      trk_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SETTLE;
               l_d     = l_clamped;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_SETTLE: begin
            // Also re-raises BUSY one cycle after a back-to-back accept
            busy_d = 1'b1;
            if (cnt_q == SETTLE_LAST) begin
               state_d   = ST_ACCUM;
               cnt_d     = '0;
               acc_d     = '0;
               trk_clear = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_ACCUM: begin
            acc_d  = acc_q + s_ext;
            trk_en = 1'b1;
            if (cnt_q == block_last) begin
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_FIN: begin
            sum_d  = acc_q;
            mean_d = acc_shift[ADC_WIDTH-1:0];
            min_d  = trk_min;
            max_d  = trk_max;
            done_d = 1'b1;
            busy_d = 1'b0;
            if (START) begin
               state_d = ST_SETTLE;
               l_d     = l_clamped;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, input pipeline and result registers
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         l_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         mean_q  <= '0;
         min_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         l_q     <= l_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         mean_q  <= mean_d;
         min_q   <= min_d;
         max_q   <= max_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign SUM_OUT  = sum_q;
   assign MEAN_OUT = mean_q;
   assign MIN_OUT  = min_q;
   assign MAX_OUT  = max_q;

endmodule

// File: tb/tb_adc_block_averager.sv
// Bench for adc_block_averager: random and directed blocks, a schedule-level
// reference model that predicts each DONE, and a monitor that checks it.
module tb_adc_block_averager;

   localparam int AW = 12;
   localparam int ML = 10;
   localparam int SC = 4;
   localparam int HIST = 32768;

   logic              ADC_CLK = 1'b0;
   logic              RST_N   = 1'b0;
   logic [AW-1:0]     ADC_DATA_IN = '0;
   logic              START = 1'b0;
   logic [3:0]        LOG2_N = '0;
   logic              BUSY;
   logic              DONE;
   logic [AW+ML-1:0]  SUM_OUT;
   logic [AW-1:0]     MEAN_OUT;
   logic [AW-1:0]     MIN_OUT;
   logic [AW-1:0]     MAX_OUT;

   adc_block_averager #(
      .ADC_WIDTH     (AW),
      .MAX_LOG2_N    (ML),
      .SETTLE_CYCLES (SC)
   ) dut (
      .ADC_CLK     (ADC_CLK),
      .RST_N       (RST_N),
      .ADC_DATA_IN (ADC_DATA_IN),
      .START       (START),
      .LOG2_N      (LOG2_N),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .SUM_OUT     (SUM_OUT),
      .MEAN_OUT    (MEAN_OUT),
      .MIN_OUT     (MIN_OUT),
      .MAX_OUT     (MAX_OUT)
   );

   // ---------------- clock ----------------
   always #5 ADC_CLK = ~ADC_CLK;

   // ---------------- bookkeeping ----------------
   typedef struct {
      longint sum;
      longint mean;
      longint mn;
      longint mx;
      int     cyc;
   } exp_t;

   exp_t    exp_q[$];
   int      n_checks = 0;
   int      n_fail = 0;
   int      cyc = 0;
   logic [AW-1:0] din_hist [0:HIST-1];

   // model run state
   logic    m_busy = 1'b0;
   int      m_t0 = 0;
   int      m_l = 0;
   int      m_done_at = 0;
   logic    exp_busy = 1'b0;
   logic    bb_pending = 1'b0;

   // observed results
   longint  last_sum = 0;
   longint  last_mean = 0;
   longint  last_min = 0;
   longint  last_max = 0;
   int      last_done_cyc = 0;
   int      done_count = 0;

   // stimulus control: 0 const, 1 random, 2 alternate extremes, 3 table
   int      din_mode = 0;
   logic [AW-1:0] din_const = '0;
   logic    alt_ph = 1'b0;
   int      tbl [0:7];
   int      tbl_idx = 0;

   task automatic check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- input data driver ----------------
   always @(posedge ADC_CLK) begin
      #2;
      case (din_mode)
         0: ADC_DATA_IN = din_const;
         1: ADC_DATA_IN = AW'($urandom_range(0, (1 << AW) - 1));
         2: begin
            ADC_DATA_IN = alt_ph ? 12'h800 : 12'h7FF;
            alt_ph = ~alt_ph;
         end
         default: begin
            if (tbl_idx < 8) ADC_DATA_IN = AW'(tbl[tbl_idx]);
            else ADC_DATA_IN = '0;
            tbl_idx++;
         end
      endcase
   end

   // ---------------- reference model ----------------
   function automatic exp_t predict(input int t0, input int l, input int done_at);
      exp_t   e;
      longint s;
      longint n;
      int     v;
      n = longint'(1) << l;
      s = 0;
      e.mn = 1 << 30;
      e.mx = -(1 << 30);
      for (int k = 0; k < int'(n); k++) begin
         v = int'($signed(din_hist[(t0 + SC + k) % HIST]));
         s += v;
         if (v < e.mn) e.mn = v;
         if (v > e.mx) e.mx = v;
      end
      e.sum  = s;
      e.mean = (s >= 0) ? (s / n) : -((-s + n - 1) / n);
      e.cyc  = done_at;
      return e;
   endfunction

   function automatic int clamp_l(input logic [3:0] l);
      return (int'(l) > ML) ? ML : int'(l);
   endfunction

   always @(posedge ADC_CLK) begin
      cyc++;
      din_hist[cyc % HIST] = ADC_DATA_IN;
      if (!RST_N) begin
         m_busy = 1'b0;
         exp_busy = 1'b0;
         bb_pending = 1'b0;
         exp_q.delete();
      end else begin
         if (bb_pending) begin
            exp_busy = 1'b1;
            bb_pending = 1'b0;
         end
         if (m_busy && cyc == m_done_at) begin
            exp_q.push_back(predict(m_t0, m_l, m_done_at));
            m_busy = 1'b0;
            exp_busy = 1'b0;
            if (START) begin
               m_busy = 1'b1;
               m_t0 = cyc;
               m_l = clamp_l(LOG2_N);
               m_done_at = cyc + SC + (1 << m_l) + 1;
               bb_pending = 1'b1;
            end
         end else if (!m_busy && START) begin
            m_busy = 1'b1;
            m_t0 = cyc;
            m_l = clamp_l(LOG2_N);
            m_done_at = cyc + SC + (1 << m_l) + 1;
            exp_busy = 1'b1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge ADC_CLK) begin
      exp_t e;
      if (RST_N) begin
         check("busy", longint'(BUSY), longint'(exp_busy));
         if (DONE) begin
            done_count++;
            last_sum  = longint'($signed(SUM_OUT));
            last_mean = longint'($signed(MEAN_OUT));
            last_min  = longint'($signed(MIN_OUT));
            last_max  = longint'($signed(MAX_OUT));
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", longint'(cyc), longint'(e.cyc));
               check("sum", last_sum, e.sum);
               check("mean", last_mean, e.mean);
               check("min", last_min, e.mn);
               check("max", last_max, e.mx);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_done", 0, 1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_run(input logic [3:0] l, output int t0);
      @(posedge ADC_CLK);
      #1;
      LOG2_N = l;
      START = 1'b1;
      @(posedge ADC_CLK);
      #1;
      t0 = cyc;
      START = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge ADC_CLK);
         if (!m_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_idle_timeout", 0, 1);
      repeat (2) @(negedge ADC_CLK);
   endtask

   task automatic check_results(input string tag, input longint s, input longint m,
                                input longint mn, input longint mx);
      check({tag, "_sum"}, last_sum, s);
      check({tag, "_mean"}, last_mean, m);
      check({tag, "_min"}, last_min, mn);
      check({tag, "_max"}, last_max, mx);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, longint'(BUSY), 0);
      check({tag, "_done"}, longint'(DONE), 0);
      check({tag, "_sum"}, longint'(SUM_OUT), 0);
      check({tag, "_mean"}, longint'(MEAN_OUT), 0);
      check({tag, "_min"}, longint'(MIN_OUT), 0);
      check({tag, "_max"}, longint'(MAX_OUT), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t0;
      int dc;

      // reset state
      repeat (3) @(posedge ADC_CLK);
      #1;
      check_outputs_zero("reset");
      @(posedge ADC_CLK);
      #2;
      RST_N = 1'b1;
      repeat (2) @(posedge ADC_CLK);

      // constant -1024, full block
      din_mode = 0;
      din_const = 12'hC00;
      start_run(4'd10, t0);
      wait_idle();
      check("const_latency", longint'(last_done_cyc - t0), SC + 1024 + 1);
      check_results("const", -1048576, -1024, -1024, -1024);

      // ramp -3..0 with floor rounding
      @(posedge ADC_CLK);
      #1;
      tbl[0] = 0; tbl[1] = 0; tbl[2] = 0; tbl[3] = 0;
      tbl[4] = -3; tbl[5] = -2; tbl[6] = -1; tbl[7] = 0;
      tbl_idx = 0;
      din_mode = 3;
      LOG2_N = 4'd2;
      START = 1'b1;
      @(posedge ADC_CLK);
      #1;
      START = 1'b0;
      wait_idle();
      check_results("ramp", -6, -2, -3, 0);

      // clamp of LOG2_N and alternating extremes
      din_mode = 2;
      start_run(4'd15, t0);
      wait_idle();
      check("clamp_latency", longint'(last_done_cyc - t0), SC + 1024 + 1);
      check_results("clamp", -512, -1, -2048, 2047);

      // START held high: back-to-back runs
      din_mode = 1;
      dc = done_count;
      @(posedge ADC_CLK);
      #1;
      LOG2_N = 4'd10;
      START = 1'b1;
      repeat (3 * (SC + 1024 + 1) + 5) @(posedge ADC_CLK);
      #1;
      START = 1'b0;
      check("hold_done_count", longint'(done_count - dc), 3);
      wait_idle();

      // random START pulses during a short run
      start_run(4'd3, t0);
      for (int i = 0; i < 24; i++) begin
         @(posedge ADC_CLK);
         #1;
         START = 1'($urandom_range(0, 1));
      end
      @(posedge ADC_CLK);
      #1;
      START = 1'b0;
      wait_idle();

      // reset in the middle of accumulation
      start_run(4'd10, t0);
      repeat (SC + 500) @(posedge ADC_CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(posedge ADC_CLK);
      #2;
      RST_N = 1'b1;
      dc = done_count;
      repeat (1200) @(posedge ADC_CLK);
      check("midreset_no_done", longint'(done_count - dc), 0);
      start_run(4'd4, t0);
      wait_idle();
      check("midreset_rerun_done", longint'(done_count - dc), 1);

      // single-sample block
      din_mode = 0;
      din_const = 12'h123;
      start_run(4'd0, t0);
      wait_idle();
      check("l0_latency", longint'(last_done_cyc - t0), SC + 2);
      check_results("l0", 291, 291, 291, 291);

      // random blocks
      din_mode = 1;
      for (int r = 0; r < 8; r++) begin
         start_run(4'($urandom_range(0, 7)), t0);
         wait_idle();
      end
      start_run(4'd12, t0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
